// File: rtl/i2c_master_burst.sv
// i2c_master_burst: register-addressed I2C master with write/read bursts, ACK checking and open-drain pins
module i2c_master_burst #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rw,
    input  logic [6:0]       dev_addr,
    input  logic [7:0]       reg_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    output logic             tx_req,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             ack_err,
    output wire              scl,
    inout  wire              sda
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_REG, S_WDATA, S_RSTART, S_ADDR_R, S_RDATA, S_STOP
    } state_t;
    state_t            r_state, w_next;
    logic [DW-1:0]     r_div;
    logic [1:0]        r_q;
    logic [3:0]        r_bit;
    logic [7:0]        r_sh, r_rx_data, r_reg, w_load_val;
    logic [6:0]        r_dev;
    logic [LEN_W-1:0]  r_left;
    logic              r_rw, r_done, r_rx_valid, r_ack_err;
    logic              w_bit_end, w_ack_end, w_sample, w_byte, w_tx, w_last, w_load;
    logic              w_scl_lo, w_sda_lo, w_cond;
    assign w_byte    = (r_state == S_ADDR_W) || (r_state == S_REG) || (r_state == S_WDATA) ||
                       (r_state == S_ADDR_R) || (r_state == S_RDATA);
    assign w_tx      = w_byte && (r_state != S_RDATA);
    assign w_cond    = (r_state == S_START) || (r_state == S_RSTART);
    assign w_bit_end = (r_state != S_IDLE) && (r_q == 2'd3) && (r_div == DW'(CLK_DIV - 1));
    assign w_ack_end = w_bit_end && (r_bit == 4'd8);
    assign w_sample  = (r_q == 2'd2) && (r_div == '0);
    assign w_last    = r_left == LEN_W'(1);
    assign w_scl_lo  = w_cond ? (r_q == 2'd3) :
                       (r_state == S_STOP) ? (r_q == 2'd0) :
                       w_byte && ((r_q == 2'd0) || (r_q == 2'd3));
    assign w_sda_lo  = w_cond ? r_q[1] :
                       (r_state == S_STOP) ? !r_q[1] :
                       !w_byte ? 1'b0 :
                       (r_bit == 4'd8) ? ((r_state == S_RDATA) && !w_last) :
                       (w_tx && !r_sh[7]);
    assign scl      = w_scl_lo ? 1'b0 : 1'bz;
    assign sda      = w_sda_lo ? 1'b0 : 1'bz;
    assign busy     = r_state != S_IDLE;
    assign done     = r_done;
    assign ack_err  = r_ack_err;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    // state register; reset drops straight back to IDLE so both lines release at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end
    // sequencing at bit boundaries, shift-register loads and the tx_req handshake
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = r_sh;
        tx_req     = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_next = S_START;
            S_START:  if (w_bit_end) begin
                w_next     = S_ADDR_W;
                w_load     = 1'b1;
                w_load_val = {r_dev, 1'b0};
            end
            S_ADDR_W: if (w_ack_end) begin
                w_next     = r_ack_err ? S_STOP : S_REG;
                w_load     = 1'b1;
                w_load_val = r_reg;
            end
            S_REG:    if (w_ack_end) begin
                w_next     = (r_ack_err || r_left == '0) ? S_STOP : (r_rw ? S_RSTART : S_WDATA);
                tx_req     = !r_ack_err && (r_left != '0) && !r_rw;
                w_load     = 1'b1;
                w_load_val = tx_data;
            end
            S_WDATA:  if (w_ack_end) begin
                w_next     = (r_ack_err || w_last) ? S_STOP : S_WDATA;
                tx_req     = !r_ack_err && !w_last;
                w_load     = 1'b1;
                w_load_val = tx_data;
            end
            S_RSTART: if (w_bit_end) begin
                w_next     = S_ADDR_R;
                w_load     = 1'b1;
                w_load_val = {r_dev, 1'b1};
            end
            S_ADDR_R: if (w_ack_end) w_next = r_ack_err ? S_STOP : S_RDATA;
            S_RDATA:  if (w_ack_end) w_next = w_last ? S_STOP : S_RDATA;
            S_STOP:   if (w_bit_end) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end
    // bit timing, request latching, shifting, ACK sampling and result strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div      <= '0;
            r_q        <= '0;
            r_bit      <= '0;
            r_sh       <= '0;
            r_rx_data  <= '0;
            r_reg      <= '0;
            r_dev      <= '0;
            r_left     <= '0;
            r_rw       <= 1'b0;
            r_done     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            r_done     <= (r_state == S_STOP) && w_bit_end;
            r_rx_valid <= 1'b0;
            if (r_state == S_IDLE) begin
                r_div <= '0;
                r_q   <= '0;
                r_bit <= '0;
                if (start) begin
                    r_rw      <= rw;
                    r_dev     <= dev_addr;
                    r_reg     <= reg_addr;
                    r_left    <= len;
                    r_ack_err <= 1'b0;
                end
            end else begin
                r_div <= (r_div == DW'(CLK_DIV - 1)) ? '0 : r_div + DW'(1);
                if (r_div == DW'(CLK_DIV - 1)) r_q <= r_q + 2'd1;
                if (w_bit_end) r_bit <= (w_byte && r_bit != 4'd8) ? r_bit + 4'd1 : 4'd0;
                if (w_load) r_sh <= w_load_val;
                else if (w_bit_end && w_tx && r_bit != 4'd8) r_sh <= {r_sh[6:0], 1'b0};
                else if (w_sample && r_state == S_RDATA && r_bit != 4'd8) r_sh <= {r_sh[6:0], sda};
                if (w_sample && r_state == S_RDATA && r_bit == 4'd7) begin
                    r_rx_data  <= {r_sh[6:0], sda};
                    r_rx_valid <= 1'b1;
                end
                if (w_sample && w_tx && r_bit == 4'd8 && sda) r_ack_err <= 1'b1;
                if (w_ack_end && (r_state == S_WDATA || r_state == S_RDATA)) r_left <= r_left - LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_burst.sv
// tb_i2c_master_burst: scoreboard bench with a behavioural slave at 0x66 on pulled-up lines
module tb_i2c_master_burst;
    localparam logic [6:0] SLV = 7'h66;
    localparam int TOK_S = 'h1000, TOK_SR = 'h1001, TOK_P = 'h1002;
    typedef struct {logic err; int busy_c; int tx_c; int rx_c;} done_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, rw = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0, tx_data = '0;
    logic [3:0] len = '0;
    logic tx_req, rx_valid, busy, done, ack_err;
    logic [7:0] rx_data;
    wire scl, sda;
    pullup (scl);
    pullup (sda);
    logic s_lo = 1'b0;
    assign sda = s_lo ? 1'b0 : 1'bz;
    int exp_tok[$];
    logic [7:0] exp_rx[$], wq[$], s_rdata[$];
    done_t exp_done[$];
    done_t m_d;
    int n_pass = 0, n_total = 0, done_seen = 0, s_nack_idx = -1;
    int m_b = 0, m_t = 0, m_r = 0;
    int s_bit = 0, s_idx = 0;
    logic s_in = 0, s_sel = 0, s_rd = 0, s_rdp = 0, s_ack = 1, p_scl = 1, p_sda = 1;
    logic [7:0] s_byte = '0, s_out = '0;

    i2c_master_burst #(.CLK_DIV(2), .LEN_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .dev_addr(dev_addr),
        .reg_addr(reg_addr), .len(len), .tx_data(tx_data), .tx_req(tx_req),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        .ack_err(ack_err), .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tok(input int t);
        if (exp_tok.size() == 0) check("bus token unexpected", t, -1);
        else check("bus token", t, exp_tok.pop_front());
    endtask

    // behavioural slave: decodes S/Sr/P and bytes, ACKs its address, serves read data
    always @(negedge clk) begin
        if (rst) begin
            s_lo = 0; s_bit = 0; s_idx = 0; s_rdp = 0; s_in = 0; s_sel = 0;
        end else if (scl && p_scl && p_sda && !sda) begin
            tok(s_in ? TOK_SR : TOK_S);
            s_in = 1; s_bit = 0; s_idx = 0; s_rdp = 0; s_lo = 0;
        end else if (scl && p_scl && !p_sda && sda) begin
            tok(TOK_P);
            s_in = 0; s_bit = 0; s_rdp = 0; s_lo = 0;
        end else if (scl && !p_scl) begin
            if (s_bit < 8) s_byte = {s_byte[6:0], sda};
            else if (s_bit == 8) begin
                s_ack = sda;
                tok({23'd0, sda, s_byte});
            end
            s_bit++;
        end else if (!scl && p_scl) begin
            if (s_bit == 8) begin
                if (s_idx == 0) begin
                    s_sel = s_byte[7:1] == SLV;
                    s_rd  = s_byte[0];
                end
                s_lo = s_rdp ? 1'b0 : (s_sel && s_idx != s_nack_idx);
            end else if (s_bit == 9) begin
                s_bit = 0;
                s_idx++;
                s_rdp = s_sel && s_rd && !s_ack;
                if (s_rdp) s_out = (s_rdata.size() != 0) ? s_rdata.pop_front() : 8'hFF;
                s_lo = s_rdp && !s_out[7];
            end else if (s_rdp && s_bit > 0 && s_bit < 8) s_lo = !s_out[7 - s_bit];
        end
        p_scl = scl;
        p_sda = sda;
    end

    // monitor: counts strobes/busy, checks rx bytes and per-transaction results on done
    always @(negedge clk) begin
        if (rst) begin
            m_b = 0; m_t = 0; m_r = 0;
        end else begin
            if (busy) m_b++;
            if (tx_req) m_t++;
            if (rx_valid) begin
                m_r++;
                if (exp_rx.size() == 0) check("rx_valid unexpected", rx_data, -1);
                else check("rx_data", rx_data, exp_rx.pop_front());
            end
            if (done) begin
                if (exp_done.size() == 0) check("done unexpected", done, 0);
                else begin
                    m_d = exp_done.pop_front();
                    check("ack_err", ack_err, m_d.err);
                    check("busy cycles", m_b, m_d.busy_c);
                    check("tx_req pulses", m_t, m_d.tx_c);
                    check("rx_valid pulses", m_r, m_d.rx_c);
                    check("busy low at done", busy, 0);
                end
                m_b = 0; m_t = 0; m_r = 0;
                done_seen++;
            end
        end
    end

    // write-data source: advance to the next byte after each tx_req capture edge
    initial forever begin
        @(negedge clk);
        if (tx_req) begin
            @(posedge clk);
            #1;
            if (wq.size() != 0) void'(wq.pop_front());
            tx_data = (wq.size() != 0) ? wq[0] : 8'h00;
        end
    end

    task automatic push_done(input logic e, input int bits, input int t, input int r);
        done_t d;
        d.err = e; d.busy_c = bits * 8; d.tx_c = t; d.rx_c = r;
        exp_done.push_back(d);
    endtask

    task automatic run(input logic r, input logic [6:0] d, input logic [7:0] ra, input logic [3:0] n);
        @(negedge clk);
        rw = r; dev_addr = d; reg_addr = ra; len = n; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input int d0, input string name);
        for (int i = 0; i < 3000 && done_seen == d0; i++) @(negedge clk);
        #1;
        check(name, done_seen - d0, 1);
        check({name, " tokens left"}, exp_tok.size(), 0);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check("reset scl", scl, 1);
        check("reset sda", sda, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset ack_err", ack_err, 0);
        check("reset tx_req", tx_req, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 0);
        rst = 0;
        repeat (2) @(negedge clk);

        wq = '{8'hB7, 8'hE4}; tx_data = 8'hB7;
        exp_tok = '{TOK_S, 'h0CC, 'h081, 'h0B7, 'h0E4, TOK_P};
        push_done(0, 38, 2, 0);
        d0 = done_seen; run(0, SLV, 8'h81, 4'd2); wait_done(d0, "write len2");

        s_rdata = '{8'h11, 8'h22, 8'h33}; exp_rx = '{8'h11, 8'h22, 8'h33};
        exp_tok = '{TOK_S, 'h0CC, 'h081, TOK_SR, 'h0CD, 'h011, 'h022, 'h133, TOK_P};
        push_done(0, 57, 0, 3);
        d0 = done_seen; run(1, SLV, 8'h81, 4'd3); wait_done(d0, "read len3");

        wq = '{8'hA1}; tx_data = 8'hA1;
        exp_tok = '{TOK_S, 'h1AA, TOK_P};
        push_done(1, 11, 0, 0);
        d0 = done_seen; run(0, 7'h55, 8'h81, 4'd1); wait_done(d0, "absent slave");

        exp_tok = '{TOK_S, 'h0CC, 'h081, TOK_P};
        push_done(0, 20, 0, 0);
        d0 = done_seen; run(1, SLV, 8'h81, 4'd0);
        repeat (40) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done(d0, "pointer-only read");
        d0 = done_seen;
        repeat (300) @(negedge clk);
        check("no second transaction", done_seen - d0, 0);
        check("idle after ignored start", busy, 0);

        s_nack_idx = 3;
        wq = '{8'hC3, 8'h5E, 8'h77}; tx_data = 8'hC3;
        exp_tok = '{TOK_S, 'h0CC, 'h081, 'h0C3, 'h15E, TOK_P};
        push_done(1, 38, 2, 0);
        d0 = done_seen; run(0, SLV, 8'h81, 4'd3); wait_done(d0, "data nack");
        s_nack_idx = -1;

        s_rdata = '{8'h11, 8'h22, 8'h33}; exp_rx = '{8'h11};
        exp_tok = '{TOK_S, 'h0CC, 'h081, TOK_SR, 'h0CD};
        run(1, SLV, 8'h81, 4'd3);
        for (int i = 0; i < 3000 && !rx_valid; i++) @(negedge clk);
        check("rx_valid before reset", rx_valid, 1);
        repeat (4) @(negedge clk);
        check("master ack scl low", scl, 0);
        check("master ack sda low", sda, 0);
        rst = 1;
        #1;
        check("async reset scl", scl, 1);
        check("async reset sda", sda, 1);
        check("async reset busy", busy, 0);
        check("async reset rx_data", rx_data, 0);
        check("async reset rx_valid", rx_valid, 0);
        check("async reset tx_req", tx_req, 0);
        check("async reset done", done, 0);
        check("async reset ack_err", ack_err, 0);
        check("tokens before reset", exp_tok.size(), 0);
        s_rdata.delete();
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);

        s_rdata = '{8'hA5, 8'h3C}; exp_rx = '{8'hA5, 8'h3C};
        exp_tok = '{TOK_S, 'h0CC, 'h081, TOK_SR, 'h0CD, 'h0A5, 'h13C, TOK_P};
        push_done(0, 48, 0, 2);
        d0 = done_seen; run(1, SLV, 8'h81, 4'd2); wait_done(d0, "read after reset");

        repeat (5) @(negedge clk);
        check("rx bytes left", exp_rx.size(), 0);
        check("done records left", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
